// File: rtl/cam_capture_ctrl_if.sv
// Processor/camera-side signal bundle for the single-frame capture sequencer.
//   init       : capture request from the processor (rising edge acts)
//   cam_vsync  : raw camera vsync, asynchronous, high = vertical blanking
//   cam_href   : raw camera href, asynchronous, high = active line
//   capture_en : frame-buffer write gate
//   status     : capture in progress
//   done       : sticky completion flag
//   err        : sticky error flag, meaningful when done = 1
//   line_cnt   : lines counted in the last capture, saturating at 255
interface cam_capture_ctrl_if;
  logic       init;
  logic       cam_vsync;
  logic       cam_href;
  logic       capture_en;
  logic       status;
  logic       done;
  logic       err;
  logic [7:0] line_cnt;

  // Driver side: processor plus camera
  modport master (
    output init, cam_vsync, cam_href,
    input  capture_en, status, done, err, line_cnt
  );

  // Capture controller side
  modport slave (
    input  init, cam_vsync, cam_href,
    output capture_en, status, done, err, line_cnt
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Single-frame capture sequencer. Arms on an init rising edge, waits for a
// fresh vsync rise/fall pair, opens the frame-buffer write gate for one frame,
// counts href lines and reports done/err back to the processor.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : cam_capture_ctrl_if.slave (init, cam_vsync, cam_href in;
//         capture_en, status, done, err, line_cnt out; all outputs registered)
module cam_capture_ctrl #(
  parameter int unsigned LINES   = 120,
  parameter int unsigned TIMEOUT = 25_000_000,
  parameter int unsigned TW      = 25
) (
  input  logic                clk,
  input  logic                rst,
  cam_capture_ctrl_if.slave   bus
);

  localparam int unsigned LCW = 8;

  typedef enum logic [1:0] {IDLE, ARM, BLANK, CAPTURE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       vs_q, hr_q;       // [1:0] synchronizer, [2] edge-detect delay
  logic             init_q;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             cap_q, cap_d;
  logic             status_q, status_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LCW-1:0]   line_q, line_d;

  logic             vs_rise, vs_fall, hr_rise, init_rise, tmo_hit;
  logic [LCW-1:0]   line_inc, line_hit;

  // Edge strobes from the synchronized level vs its delayed copy
  assign vs_rise   = (vs_q[1] ^ vs_q[2]) &  vs_q[1];
  assign vs_fall   = (vs_q[1] ^ vs_q[2]) & ~vs_q[1];
  assign hr_rise   = (hr_q[1] ^ hr_q[2]) &  hr_q[1];
  assign init_rise = bus.init & ~init_q;
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

  // Saturating line count, including an href rise seen this cycle
  assign line_inc  = (line_q == '1) ? line_q : line_q + LCW'(1);
  assign line_hit  = hr_rise ? line_inc : line_q;

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    cap_d    = cap_q;
    done_d   = done_q;
    err_d    = err_q;
    line_d   = line_q;

    case (state_q)
      IDLE: begin
        if (init_rise) begin
          state_d = ARM;
          done_d  = 1'b0;
          err_d   = 1'b0;
          line_d  = '0;
          tmo_d   = '0;
        end
      end
      default: begin
        tmo_d = tmo_q + TW'(1);
        if (state_q == CAPTURE) line_d = line_hit;
        // Timeout wins over any vsync edge in the same cycle
        if (tmo_hit) begin
          state_d = IDLE;
          cap_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          case (state_q)
            ARM:   if (vs_rise) state_d = BLANK;
            BLANK: if (vs_fall) begin
              state_d = CAPTURE;
              cap_d   = 1'b1;
              line_d  = '0;
            end
            CAPTURE: if (vs_rise) begin
              state_d = IDLE;
              cap_d   = 1'b0;
              done_d  = 1'b1;
              err_d   = (line_hit != LCW'(LINES));
            end
            default: state_d = state_q;
          endcase
        end
      end
    endcase

    // Derived from next state so status and done change on the same edge
    status_d = (state_d != IDLE);
  end

  // State, synchronizers and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      vs_q     <= '0;
      hr_q     <= '0;
      init_q   <= 1'b0;
      tmo_q    <= '0;
      cap_q    <= 1'b0;
      status_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      vs_q     <= {vs_q[1:0], bus.cam_vsync};
      hr_q     <= {hr_q[1:0], bus.cam_href};
      init_q   <= bus.init;
      tmo_q    <= tmo_d;
      cap_q    <= cap_d;
      status_q <= status_d;
      done_q   <= done_d;
      err_q    <= err_d;
      line_q   <= line_d;
    end
  end

  assign bus.capture_en = cap_q;
  assign bus.status     = status_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.line_cnt   = line_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl: table of frames with expected
// done/err/line_cnt, a scoreboard queue popped on each done rise, and
// hand-written sequences for arm, busy, reset and timeout corner cases.
module tb_cam_capture_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic       err;
    logic [7:0] lines;
  } exp_t;

  typedef struct {
    int         n_href;
    logic       exp_err;
    logic [7:0] exp_lines;
  } vec_t;

  exp_t sb[$];

  cam_capture_ctrl_if bus();
  cam_capture_ctrl_if bus_to();

  cam_capture_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cam_capture_ctrl #(.LINES(120), .TIMEOUT(50), .TW(6)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_to)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // capture_en edge recorder
  logic cap_prev = 1'b0;
  int   cap_rise_cyc = 0, cap_fall_cyc = 0, cap_rises = 0, cap_falls = 0;
  always @(negedge clk) begin
    if (bus.capture_en && !cap_prev) begin cap_rise_cyc = cyc; cap_rises++; end
    if (!bus.capture_en && cap_prev) begin cap_fall_cyc = cyc; cap_falls++; end
    cap_prev = bus.capture_en;
  end

  int fall_drv = 0, rise_drv = 0, rises0 = 0, falls0 = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    tick(1);
    bus.init = 1'b0;
  endtask

  task automatic vsync_to(input logic v);
    bus.cam_vsync = v;
    if (v) rise_drv = cyc; else fall_drv = cyc;
  endtask

  task automatic lines(input int n);
    repeat (n) begin
      bus.cam_href = 1'b1; tick(8);
      bus.cam_href = 1'b0; tick(4);
    end
  endtask

  task automatic push_exp(input logic e, input logic [7:0] l);
    exp_t x;
    x.err = e; x.lines = l;
    sb.push_back(x);
  endtask

  // Wait (bounded) for done to rise, then score against the queue
  task automatic wait_done(input int budget);
    exp_t x;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check("done_seen", int'(bus.done), 1);
    check("sb_pending", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("err", int'(bus.err), int'(x.err));
      check("line_cnt", int'(bus.line_cnt), int'(x.lines));
    end
  endtask

  task automatic frame_begin();
    rises0 = cap_rises; falls0 = cap_falls;
    vsync_to(1'b1); tick(10);
    vsync_to(1'b0); tick(6);
  endtask

  task automatic frame_end();
    tick(4);
    vsync_to(1'b1);
    wait_done(20);
    @(posedge clk); #1;
    check("status_end", int'(bus.status), 0);
    check("cap_end", int'(bus.capture_en), 0);
    check("cap_rise_lat", cap_rise_cyc - fall_drv, 3);
    check("cap_fall_lat", cap_fall_cyc - rise_drv, 3);
    check("cap_rise_cnt", cap_rises - rises0, 1);
    check("cap_fall_cnt", cap_falls - falls0, 1);
    tick(8);
    vsync_to(1'b0);
    tick(4);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cap"},  int'(bus.capture_en), 0);
    check({tag, "_stat"}, int'(bus.status), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_err"},  int'(bus.err), 0);
    check({tag, "_line"}, int'(bus.line_cnt), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   n;
    tbl = '{'{120, 1'b0, 8'd120}, '{100, 1'b1, 8'd100}, '{0,   1'b1, 8'd0},
            '{300, 1'b1, 8'd255}, '{119, 1'b1, 8'd119}, '{121, 1'b1, 8'd121}};

    bus_to.init = 1'b0; bus_to.cam_vsync = 1'b0; bus_to.cam_href = 1'b0;

    // Reset with random inputs
    repeat (4) begin
      bus.init = 1'($urandom); bus.cam_vsync = 1'($urandom); bus.cam_href = 1'($urandom);
      @(negedge clk);
    end
    check_idle("rst");
    check("rst_to_stat", int'(bus_to.status), 0);
    check("rst_to_done", int'(bus_to.done), 0);
    bus.init = 1'b0; bus.cam_vsync = 1'b0; bus.cam_href = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(10);
    check_idle("post_rst");

    // Table-driven frames
    foreach (tbl[i]) begin
      push_exp(tbl[i].exp_err, tbl[i].exp_lines);
      pulse_init();
      tick(3);
      check("armed_status", int'(bus.status), 1);
      frame_begin();
      lines(tbl[i].n_href);
      frame_end();
    end

    // Arm mid-frame: href activity before a full vsync sequence is ignored
    push_exp(1'b0, 8'd120);
    pulse_init();
    lines(20);
    check("mid_cap", int'(bus.capture_en), 0);
    check("mid_line", int'(bus.line_cnt), 0);
    check("mid_stat", int'(bus.status), 1);
    frame_begin();
    lines(120);
    frame_end();

    // Arm with vsync already high: the following fall must not start capture
    push_exp(1'b0, 8'd120);
    vsync_to(1'b1); tick(3);
    pulse_init();
    tick(5);
    vsync_to(1'b0); tick(4);
    lines(10);
    check("vshi_cap", int'(bus.capture_en), 0);
    check("vshi_line", int'(bus.line_cnt), 0);
    frame_begin();
    lines(120);
    frame_end();

    // Second init during capture is ignored
    push_exp(1'b0, 8'd120);
    pulse_init(); tick(3);
    frame_begin();
    lines(30);
    pulse_init();
    tick(2);
    check("busy_stat", int'(bus.status), 1);
    check("busy_cap", int'(bus.capture_en), 1);
    check("busy_line", int'(bus.line_cnt), 30);
    lines(90);
    frame_end();

    // Reset mid-capture, then a clean capture
    pulse_init(); tick(3);
    frame_begin();
    lines(60);
    check("pre_rst_cap", int'(bus.capture_en), 1);
    rst = 1'b0;
    #1;
    check_idle("mid_rst");
    tick(2);
    rst = 1'b1;
    tick(2);
    push_exp(1'b0, 8'd120);
    pulse_init(); tick(3);
    frame_begin();
    lines(120);
    frame_end();
    check("sb_drained", sb.size(), 0);

    // Timeout on the short-timeout instance
    @(posedge clk); #1;
    bus_to.init = 1'b1;
    @(negedge clk);
    check("to_lat0", int'(bus_to.status), 0);
    @(posedge clk); #1;
    bus_to.init = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus_to.status) break;
      n++;
    end
    check("to_cycles", n, 50);
    check("to_done", int'(bus_to.done), 1);
    check("to_err", int'(bus_to.err), 1);
    check("to_cap", int'(bus_to.capture_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
